mem_access_ctrl: RTL and testbench

Load/store front end that sits directly upstream of the single-port word RAM (`mem`). It turns CPU byte-addressed load/store requests (B/H/W, signed/unsigned) into word accesses, and absorbs the RAM's one-cycle registered read latency. Sub-word stores are done as read-modify-write, because the RAM has only full-word writes. Load results are sign- or zero-extended, and a single-cycle response is returned to the pipeline.

---
 rtl/mem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store front end for a single-port,
// full-word-write RAM with a one-cycle registered read.
// Handles B/H/W loads (sign/zero extended) and stores. Sub-word stores are
// done as read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// H/W accesses return rsp_err instead of using the addressed lane.
module mem_access_ctrl #(
  parameter int ADDR_LEN = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_LEN-1:0] mem_addr,
  input  logic [31:0]         mem_rd_data,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_data
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic        req_bad;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr_hi;

  // Address bits above the RAM window alias and are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:ADDR_LEN+2];

  assign req_ready = (state == IDLE) && !rst;

  // Classify an incoming request as illegal (bad width code or, optionally, misaligned).
  always_comb begin
    req_bad = 1'b0;
    if (req_we)
      req_bad = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      req_bad = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]);
`ifdef MISALIGN_TRAP_EN
    if (!req_bad) begin
      if (req_funct3[1:0] == 2'b01 && req_addr[0])
        req_bad = 1'b1;
      if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
        req_bad = 1'b1;
    end
`else
    // Without trapping, H uses addr[1] only and W ignores addr[1:0].
`endif
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    sel_byte = 8'h00;
    case (lat_off)
      2'd0: sel_byte = mem_rd_data[7:0];
      2'd1: sel_byte = mem_rd_data[15:8];
      2'd2: sel_byte = mem_rd_data[23:16];
      2'd3: sel_byte = mem_rd_data[31:24];
      default: sel_byte = 8'h00;
    endcase
    sel_half = lat_off[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    load_ext = 32'h0;
    case (lat_funct3)
      3'b000: load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001: load_ext = {{16{sel_half[15]}}, sel_half};
      3'b010: load_ext = mem_rd_data;
      3'b100: load_ext = {24'h0, sel_byte};
      3'b101: load_ext = {16'h0, sel_half};
      default: load_ext = 32'h0;
    endcase
  end

  // Merge the store byte/half into the old word, leaving other lanes untouched.
  always_comb begin
    merged = mem_rd_data;
    if (lat_funct3[1:0] == 2'b00) begin
      case (lat_off)
        2'd0: merged[7:0]   = lat_wdata[7:0];
        2'd1: merged[15:8]  = lat_wdata[7:0];
        2'd2: merged[23:16] = lat_wdata[7:0];
        2'd3: merged[31:24] = lat_wdata[7:0];
        default: merged = mem_rd_data;
      endcase
    end else if (lat_off[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  // Main FSM with all outputs registered; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_funct3  <= 3'b000;
      lat_off     <= 2'b00;
      lat_wdata   <= 16'h0;
      mem_addr    <= '0;
      mem_wr_data <= 32'h0;
      mem_wr_req  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
    end else begin
      mem_wr_req <= 1'b0;
      rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_off    <= req_addr[1:0];
            lat_wdata  <= req_wdata[15:0];
            mem_addr   <= req_addr[ADDR_LEN+1:2];
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            if (req_bad) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_we && req_funct3[1:0] == 2'b10) begin
              mem_wr_data <= req_wdata;
              mem_wr_req  <= 1'b1;
              state       <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          if (lat_we) begin
            mem_wr_data <= merged;
            mem_wr_req  <= 1'b1;
            state       <= WR;
          end else begin
            rsp_rdata <= load_ext;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WR: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a behavioural word RAM plus a table of
// directed load/store vectors, followed by a reset-during-RMW sequence.
module tb_mem_access_ctrl;

  localparam int ADDR_LEN = 11;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int C_LD  = 3;
  localparam int C_SW  = 2;
  localparam int C_RMW = 4;
  localparam int C_ERR = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [31:0]         req_addr;
  logic [31:0]         req_wdata;
  logic                rsp_valid;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [31:0]         mem_rd_data;
  logic                mem_wr_req;
  logic [31:0]         mem_wr_data;

  logic [31:0] ram [0:(1<<ADDR_LEN)-1];

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_wr_cyc;
  } vec_t;

  vec_t vecs[$];

  mem_access_ctrl #(.ADDR_LEN(ADDR_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_req (mem_wr_req),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  // Single-port RAM with full-word writes and one-cycle registered read.
  always @(posedge clk) begin
    if (mem_wr_req)
      ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  function automatic vec_t mk(string name, logic we, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err,
                              int exp_cyc, int exp_wr_cyc);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_cyc = exp_cyc; v.exp_wr_cyc = exp_wr_cyc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Issue one request, follow it to its response and compare timing and data.
  task automatic applyStimulus(input vec_t v);
    int          rsp_cyc = 0;
    int          wr_cnt  = 0;
    int          wr_cyc  = 0;
    logic        got     = 1'b0;
    logic        done    = 1'b0;
    logic [31:0] rdata   = 32'h0;
    logic        err     = 1'b0;
    @(negedge clk);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    checkOutput({v.name, " ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 12 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        req_we     = 1'($urandom);
      end
      if (mem_wr_req) begin
        wr_cnt++;
        wr_cyc = k;
      end
      if (got) begin
        checkOutput({v.name, " pulse_end"}, {31'b0, rsp_valid}, 32'd0);
        done = 1'b1;
      end else if (rsp_valid) begin
        got     = 1'b1;
        rsp_cyc = k;
        rdata   = rsp_rdata;
        err     = rsp_err;
      end
    end
    checkOutput({v.name, " rsp_seen"}, {31'b0, got}, 32'd1);
    checkOutput({v.name, " rsp_cycle"}, rsp_cyc, v.exp_cyc);
    checkOutput({v.name, " rdata"}, rdata, v.exp_rdata);
    checkOutput({v.name, " err"}, {31'b0, err}, {31'b0, v.exp_err});
    checkOutput({v.name, " writes"}, wr_cnt, (v.exp_wr_cyc != 0) ? 32'd1 : 32'd0);
    if (v.exp_wr_cyc != 0)
      checkOutput({v.name, " wr_cycle"}, wr_cyc, v.exp_wr_cyc);
  endtask

  // Reset during the WAIT of a byte RMW: outputs clear at once, RAM untouched.
  task automatic resetMidRmw();
    int wr_cnt = 0;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("rstmid rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstmid rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("rstmid rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rstmid mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
    checkOutput("rstmid mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rstmid mem_wr_data", mem_wr_data, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_req) wr_cnt++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr_req || rsp_valid) wr_cnt++;
    end
    checkOutput("rstmid no_activity", wr_cnt, 32'd0);
    checkOutput("rstmid ready_after", {31'b0, req_ready}, 32'd1);
  endtask

  // Abort the run if something wedges so badly the tasks never return.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  // Main sequence: reset checks, vector table, then reset-during-RMW.
  initial begin
    for (int i = 0; i < (1 << ADDR_LEN); i++) ram[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_wr_data", mem_wr_data, 32'd0);
    rst = 1'b0;

    vecs.push_back(mk("SW 10",   1, 3'b010, 32'h10, 32'h12345678, 32'h0,        0, C_SW,  1));
    vecs.push_back(mk("LW 10a",  0, 3'b010, 32'h10, 32'h0,        32'h12345678, 0, C_LD,  0));
    vecs.push_back(mk("SB 11",   1, 3'b000, 32'h11, 32'h555555AB, 32'h0,        0, C_RMW, 3));
    vecs.push_back(mk("LW 10b",  0, 3'b010, 32'h10, 32'h0,        32'h1234AB78, 0, C_LD,  0));
    vecs.push_back(mk("LB 11",   0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAB, 0, C_LD,  0));
    vecs.push_back(mk("LBU 11",  0, 3'b100, 32'h11, 32'h0,        32'h000000AB, 0, C_LD,  0));
    vecs.push_back(mk("LB 10",   0, 3'b000, 32'h10, 32'h0,        32'h00000078, 0, C_LD,  0));
    vecs.push_back(mk("SH 12",   1, 3'b001, 32'h12, 32'h77778001, 32'h0,        0, C_RMW, 3));
    vecs.push_back(mk("LW 10c",  0, 3'b010, 32'h10, 32'h0,        32'h8001AB78, 0, C_LD,  0));
    vecs.push_back(mk("LH 12",   0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 0, C_LD,  0));
    vecs.push_back(mk("LHU 12",  0, 3'b101, 32'h12, 32'h0,        32'h00008001, 0, C_LD,  0));
    vecs.push_back(mk("LH 10",   0, 3'b001, 32'h10, 32'h0,        32'hFFFFAB78, 0, C_LD,  0));
    vecs.push_back(mk("LHU 10",  0, 3'b101, 32'h10, 32'h0,        32'h0000AB78, 0, C_LD,  0));
    vecs.push_back(mk("LB 13",   0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 0, C_LD,  0));
    vecs.push_back(TRAP ? mk("LW 13", 0, 3'b010, 32'h13, 32'h0, 32'h0, 1, C_ERR, 0)
                        : mk("LW 13", 0, 3'b010, 32'h13, 32'h0, 32'h8001AB78, 0, C_LD, 0));
    vecs.push_back(TRAP ? mk("LH 13", 0, 3'b001, 32'h13, 32'h0, 32'h0, 1, C_ERR, 0)
                        : mk("LH 13", 0, 3'b001, 32'h13, 32'h0, 32'hFFFF8001, 0, C_LD, 0));
    vecs.push_back(mk("LD f011", 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, C_ERR, 0));
    vecs.push_back(mk("LD f110", 0, 3'b110, 32'h10, 32'h0,        32'h0,        1, C_ERR, 0));
    vecs.push_back(mk("ST f100", 1, 3'b100, 32'h10, 32'hDEADBEEF, 32'h0,        1, C_ERR, 0));
    vecs.push_back(mk("ST f111", 1, 3'b111, 32'h10, 32'hDEADBEEF, 32'h0,        1, C_ERR, 0));
    vecs.push_back(mk("LW 10d",  0, 3'b010, 32'h10, 32'h0,        32'h8001AB78, 0, C_LD,  0));
    vecs.push_back(mk("LW alias",0, 3'b010, 32'h2010, 32'h0,      32'h8001AB78, 0, C_LD,  0));
    vecs.push_back(mk("SB 14",   1, 3'b000, 32'h14, 32'hFFFFFF11, 32'h0,        0, C_RMW, 3));
    vecs.push_back(mk("SB 17",   1, 3'b000, 32'h17, 32'h00000022, 32'h0,        0, C_RMW, 3));
    vecs.push_back(mk("SH 14",   1, 3'b001, 32'h14, 32'h0000BEEF, 32'h0,        0, C_RMW, 3));
    vecs.push_back(mk("LW 14",   0, 3'b010, 32'h14, 32'h0,        32'h2200BEEF, 0, C_LD,  0));
    vecs.push_back(mk("SW alias",1, 3'b010, 32'h2018, 32'hCAFEF00D, 32'h0,      0, C_SW,  1));
    vecs.push_back(mk("LW 18",   0, 3'b010, 32'h18, 32'h0,        32'hCAFEF00D, 0, C_LD,  0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    resetMidRmw();
    applyStimulus(mk("LW after rst", 0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 0, C_LD, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
